// File: rtl/l0_seq_ctrl_pkg.sv
// Shared definitions for the L0 row-FIFO sequencer: default sizing,
// the sequencer state encoding and a small sizing helper.
package l0_seq_ctrl_pkg;

    // Default number of L0 row FIFOs driven by one sequencer.
    localparam int ROW_DEF     = 8;
    // Default SRAM address width.
    localparam int ADDR_BW_DEF = 11;
    // Default vector-count width (holds 0..64).
    localparam int LEN_BW_DEF  = 7;

    // Sequencer states: load SRAM into L0, drain L0, wait for the row stagger
    // to finish, then pulse done.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        TAIL  = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Width of the tail counter, which counts 0..rows-2.
    function automatic int tail_cnt_width(input int rows);
        return (rows > 2) ? $clog2(rows - 1) : 1;
    endfunction

endpackage

// File: rtl/l0_wr_pipe.sv
// Read-to-write pipeline between SRAM and the L0 row FIFOs.
// SRAM data appears one cycle after a read is issued; the matching L0 write
// fires then, unless L0 is full, in which case the write is parked in a
// one-entry pending slot until L0 has room again.
module l0_wr_pipe (
    input  logic clk,
    input  logic reset,
    input  logic rd_issue_i,
    input  logic l0_full_i,
    output logic l0_wr_o
);

    logic data_vld_q;
    logic data_vld_d;
    logic pend_q;
    logic pend_d;
    logic wr_due;

    // A write is due for fresh SRAM data or a parked entry; it fires only when
    // L0 can accept it, otherwise it is (re)parked. The sequencer never issues
    // a read while L0 is full, so fresh data and a parked entry never coexist.
    always_comb begin
        wr_due     = data_vld_q | pend_q;
        l0_wr_o    = wr_due & ~l0_full_i;
        data_vld_d = rd_issue_i;
        pend_d     = wr_due & l0_full_i;
    end

    // Pipeline and pending registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_vld_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            data_vld_q <= data_vld_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/l0_seq_ctrl.sv
// L0 sequencer: moves a job of len vectors from SRAM into the L0 row FIFOs,
// then reads them back out of L0, waits for the row stagger to complete and
// pulses done. The read-to-write pipeline lives in l0_wr_pipe.
module l0_seq_ctrl
    import l0_seq_ctrl_pkg::*;
#(
    parameter int row     = ROW_DEF,
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int len_bw  = LEN_BW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               xw_mode,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [len_bw-1:0]  len,
    input  logic               l0_full,
    output logic               sram_cen,
    output logic [addr_bw-1:0] sram_addr,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic               o_xw_mode,
    output logic               busy,
    output logic               done
);

    localparam int                TAIL_W    = tail_cnt_width(row);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'((row > 1) ? row - 2 : 0);
    localparam logic [TAIL_W-1:0] TAIL_ONE  = TAIL_W'(1);
    localparam logic [len_bw-1:0] LEN_ONE   = len_bw'(1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [addr_bw-1:0] base_q;
    logic [addr_bw-1:0] base_d;
    logic [len_bw-1:0]  len_q;
    logic [len_bw-1:0]  len_d;
    logic               xw_q;
    logic               xw_d;
    logic [len_bw-1:0]  rd_cnt_q;
    logic [len_bw-1:0]  rd_cnt_d;
    logic [len_bw-1:0]  wr_cnt_q;
    logic [len_bw-1:0]  wr_cnt_d;
    logic [len_bw-1:0]  drn_cnt_q;
    logic [len_bw-1:0]  drn_cnt_d;
    logic [TAIL_W-1:0]  tail_cnt_q;
    logic [TAIL_W-1:0]  tail_cnt_d;

    logic start_acc;
    logic rd_issue;
    logic wr_last;
    logic drn_last;
    logic tail_last;

    // Job-progress flags derived from the counters.
    always_comb begin
        start_acc = (state_q == IDLE) && start;
        wr_last   = (wr_cnt_q == len_q - LEN_ONE);
        drn_last  = (drn_cnt_q == len_q - LEN_ONE);
        tail_last = (tail_cnt_q == TAIL_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, and an empty job
    // goes straight to DONE. With a single row there is no stagger to wait for.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (l0_wr && wr_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drn_last) begin
                    state_d = (row > 1) ? TAIL : DONE;
                end
            end
            TAIL: begin
                if (tail_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic; reads are issued only in LOAD while vectors remain and L0
    // has room, and the address bus idles at zero between reads.
    always_comb begin
        rd_issue  = (state_q == LOAD) && (rd_cnt_q != len_q) && !l0_full;
        sram_cen  = !rd_issue;
        sram_addr = rd_issue ? (base_q + addr_bw'(rd_cnt_q)) : '0;
        l0_rd     = (state_q == DRAIN);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        o_xw_mode = xw_q;
    end

    // Job capture and progress counters; everything is re-armed when a start
    // is accepted so each job begins from a clean slate.
    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        xw_d       = xw_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        drn_cnt_d  = drn_cnt_q;
        tail_cnt_d = tail_cnt_q;
        if (start_acc) begin
            base_d     = base_addr;
            len_d      = len;
            xw_d       = xw_mode;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            drn_cnt_d  = '0;
            tail_cnt_d = '0;
        end
        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + LEN_ONE;
        end
        if (l0_wr) begin
            wr_cnt_d = wr_cnt_q + LEN_ONE;
        end
        if (state_q == DRAIN) begin
            drn_cnt_d = drn_cnt_q + LEN_ONE;
        end
        if (state_q == TAIL) begin
            tail_cnt_d = tail_cnt_q + TAIL_ONE;
        end
    end

    // Job and counter registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            len_q      <= '0;
            xw_q       <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            drn_cnt_q  <= '0;
            tail_cnt_q <= '0;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            xw_q       <= xw_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            drn_cnt_q  <= drn_cnt_d;
            tail_cnt_q <= tail_cnt_d;
        end
    end

    l0_wr_pipe u_wr_pipe (
        .clk        (clk),
        .reset      (reset),
        .rd_issue_i (rd_issue),
        .l0_full_i  (l0_full),
        .l0_wr_o    (l0_wr)
    );

endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Self-checking bench for l0_seq_ctrl with default sizing (row=8, addr_bw=11,
// len_bw=7): a cycle-by-cycle vector table plus directed multi-cycle jobs.
module tb_l0_seq_ctrl;

    localparam int ADDR_BW = 11;
    localparam int LEN_BW  = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               xw_mode;
    logic [ADDR_BW-1:0] base_addr;
    logic [LEN_BW-1:0]  len;
    logic               l0_full;
    logic               sram_cen;
    logic [ADDR_BW-1:0] sram_addr;
    logic               l0_wr;
    logic               l0_rd;
    logic               o_xw_mode;
    logic               busy;
    logic               done;

    // Free-running clock.
    always #5 clk = ~clk;

    l0_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .xw_mode   (xw_mode),
        .base_addr (base_addr),
        .len       (len),
        .l0_full   (l0_full),
        .sram_cen  (sram_cen),
        .sram_addr (sram_addr),
        .l0_wr     (l0_wr),
        .l0_rd     (l0_rd),
        .o_xw_mode (o_xw_mode),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic               start;
        logic               xw;
        logic [ADDR_BW-1:0] base;
        logic [LEN_BW-1:0]  len;
        logic               full;
        logic               cen;
        logic [ADDR_BW-1:0] addr;
        logic               wr;
        logic               rd;
        logic               oxw;
        logic               busy;
        logic               done;
    } vec_t;

    vec_t vecs[$];
    int   nChecks;
    int   nFails;

    int                 jobRd;
    int                 jobWr;
    int                 jobDrn;
    int                 jobBusy;
    int                 jobFullRd;
    int                 jobFullWr;
    int                 jobDone;
    int                 jobDoneCyc;
    int                 jobWr2Cyc;
    logic [ADDR_BW-1:0] jobAddrs[$];

    function automatic vec_t mk(input logic st, input logic x, input logic [ADDR_BW-1:0] b,
                                input logic [LEN_BW-1:0] l, input logic cen,
                                input logic [ADDR_BW-1:0] a, input logic wr, input logic rd,
                                input logic oxw, input logic bsy, input logic dn);
        vec_t v;
        v.start = st;
        v.xw    = x;
        v.base  = b;
        v.len   = l;
        v.full  = 1'b0;
        v.cen   = cen;
        v.addr  = a;
        v.wr    = wr;
        v.rd    = rd;
        v.oxw   = oxw;
        v.busy  = bsy;
        v.done  = dn;
        return v;
    endfunction

    function automatic logic [31:0] addrAt(input int i);
        if (i < jobAddrs.size()) return 32'(jobAddrs[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string name, input int step, input logic [31:0] got,
                               input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        xw_mode   = v.xw;
        base_addr = v.base;
        len       = v.len;
        l0_full   = v.full;
        #2;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllOutputs(input string tag, input int step, input vec_t v);
        checkOutput({tag, "_sram_cen"},  step, 32'(sram_cen),  32'(v.cen));
        checkOutput({tag, "_sram_addr"}, step, 32'(sram_addr), 32'(v.addr));
        checkOutput({tag, "_l0_wr"},     step, 32'(l0_wr),     32'(v.wr));
        checkOutput({tag, "_l0_rd"},     step, 32'(l0_rd),     32'(v.rd));
        checkOutput({tag, "_o_xw_mode"}, step, 32'(o_xw_mode), 32'(v.oxw));
        checkOutput({tag, "_busy"},      step, 32'(busy),      32'(v.busy));
        checkOutput({tag, "_done"},      step, 32'(done),      32'(v.done));
    endtask

    // Runs one job from a start in cycle 0 for nCycles cycles, holding l0_full
    // high in cycles fullLo..fullHi, and tallies what the DUT did.
    task automatic runJob(input logic [ADDR_BW-1:0] b, input logic [LEN_BW-1:0] l,
                          input logic x, input int fullLo, input int fullHi, input int nCycles);
        jobRd = 0; jobWr = 0; jobDrn = 0; jobBusy = 0; jobFullRd = 0; jobFullWr = 0;
        jobDone = 0; jobDoneCyc = -1; jobWr2Cyc = -1;
        jobAddrs.delete();
        for (int c = 0; c < nCycles; c++) begin
            start     = (c == 0);
            base_addr = b;
            len       = l;
            xw_mode   = x;
            l0_full   = (c >= fullLo) && (c <= fullHi);
            #2;
            if (!sram_cen) begin
                jobRd++;
                jobAddrs.push_back(sram_addr);
                if (l0_full) jobFullRd++;
            end
            if (l0_wr) begin
                jobWr++;
                if (l0_full) jobFullWr++;
                if (jobWr == 2) jobWr2Cyc = c;
            end
            if (l0_rd) jobDrn++;
            if (busy) jobBusy++;
            if (done) begin
                jobDone++;
                jobDoneCyc = c;
            end
            stepCycle();
        end
        start   = 1'b0;
        l0_full = 1'b0;
    endtask

    // Cycle-accurate table: len=4 job at 0x010 with starts during LOAD and
    // DONE that must be ignored, followed by an empty job.
    task automatic buildTable();
        vecs.push_back(mk(1, 1, 11'h010, 7'd4, 1, 11'h000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 0, 11'h010, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 11'h123, 7'd0, 0, 11'h011, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 0, 11'h012, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 0, 11'h013, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 1, 0, 1, 1, 0));
        for (int c = 6; c <= 9; c++)
            vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 1, 1, 1, 0));
        for (int c = 10; c <= 16; c++)
            vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 11'h200, 7'd4, 1, 11'h000, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'h055, 7'd0, 1, 11'h000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 0, 0, 0));
    endtask

    initial begin
        logic [ADDR_BW-1:0] expWrap[4];
        vec_t               idleVec;
        int                 quietStrobes;
        int                 quietDone;

        nChecks   = 0;
        nFails    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        xw_mode   = 1'b0;
        base_addr = '0;
        len       = '0;
        l0_full   = 1'b0;
        idleVec   = mk(0, 0, 11'h000, 7'd0, 1, 11'h000, 0, 0, 0, 0, 0);
        buildTable();

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        start = 1'b1; len = 7'd4; xw_mode = 1'b1; base_addr = 11'h010;
        #2;
        checkAllOutputs("reset", 0, idleVec);
        stepCycle();
        reset = 1'b0;
        start = 1'b0;
        #2;
        checkAllOutputs("post_reset", 1, idleVec);
        stepCycle();

        $display("[TB] vector table, %0d steps", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkAllOutputs("vec", i, vecs[i]);
            stepCycle();
        end

        $display("[TB] len=3 with l0_full over the second write");
        runJob(11'h100, 7'd3, 1'b0, 3, 5, 25);
        checkOutput("stall_writes",       0, 32'(jobWr),     32'd3);
        checkOutput("stall_reads",        0, 32'(jobRd),     32'd3);
        checkOutput("stall_reads_full",   0, 32'(jobFullRd), 32'd0);
        checkOutput("stall_writes_full",  0, 32'(jobFullWr), 32'd0);
        checkOutput("stall_wr2_cycle",    0, 32'(jobWr2Cyc), 32'd6);
        checkOutput("stall_drain_cycles", 0, 32'(jobDrn),    32'd3);
        checkOutput("stall_done_count",   0, 32'(jobDone),   32'd1);
        checkOutput("stall_done_cycle",   0, 32'(jobDoneCyc), 32'd18);
        checkOutput("stall_busy_cycles",  0, 32'(jobBusy),   32'd18);
        for (int i = 0; i < 3; i++)
            checkOutput("stall_addr", i, addrAt(i), 32'h100 + 32'(i));

        $display("[TB] address wrap from 0x7FE");
        expWrap = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        runJob(11'h7FE, 7'd4, 1'b1, -1, -1, 25);
        checkOutput("wrap_reads",     0, 32'(jobRd),      32'd4);
        checkOutput("wrap_writes",    0, 32'(jobWr),      32'd4);
        checkOutput("wrap_done_cycle", 0, 32'(jobDoneCyc), 32'd17);
        for (int i = 0; i < 4; i++)
            checkOutput("wrap_addr", i, addrAt(i), 32'(expWrap[i]));

        $display("[TB] reset during DRAIN of len=8");
        for (int c = 0; c < 15; c++) begin
            start     = (c == 0);
            base_addr = 11'h020;
            len       = 7'd8;
            xw_mode   = 1'b1;
            reset     = (c == 12);
            #2;
            if (c == 11) checkOutput("abort_in_drain", c, 32'(l0_rd), 32'd1);
            if (c == 13) checkAllOutputs("abort", c, idleVec);
            stepCycle();
        end
        start        = 1'b0;
        reset        = 1'b0;
        quietStrobes = 0;
        quietDone    = 0;
        for (int c = 0; c < 30; c++) begin
            #2;
            if (!sram_cen || l0_wr || l0_rd || busy) quietStrobes++;
            if (done) quietDone++;
            stepCycle();
        end
        checkOutput("abort_quiet_strobes", 0, 32'(quietStrobes), 32'd0);
        checkOutput("abort_quiet_done",    0, 32'(quietDone),    32'd0);

        $display("[TB] clean job after abort");
        runJob(11'h040, 7'd2, 1'b0, -1, -1, 20);
        checkOutput("rerun_reads",      0, 32'(jobRd),      32'd2);
        checkOutput("rerun_writes",     0, 32'(jobWr),      32'd2);
        checkOutput("rerun_drain",      0, 32'(jobDrn),     32'd2);
        checkOutput("rerun_done_count", 0, 32'(jobDone),    32'd1);
        checkOutput("rerun_done_cycle", 0, 32'(jobDoneCyc), 32'd13);
        checkOutput("rerun_busy",       0, 32'(jobBusy),    32'd13);
        checkOutput("rerun_addr0",      0, addrAt(0),       32'h040);
        checkOutput("rerun_addr1",      1, addrAt(1),       32'h041);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
